// File: rtl/vedic_pkg.sv
// Shared types and sizing helpers for the sequential Vedic (Urdhva-Tiryakbhyam) multiplier family.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COLUMN = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Width of the column-sum / carry register for a given operand width.
    function automatic int colw(input int width);
        return $clog2(width) + 2;
    endfunction

    // Number of product columns evaluated for a given operand width.
    function automatic int cols(input int width);
        return 2 * width - 1;
    endfunction

endpackage

// File: rtl/vedic_mult_seq_column.sv
// Crosswise column unit: carry_in plus the popcount of all ra[i] & rb[j] pairs with i + j == k.
module vedic_column_sum
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = colw(WIDTH),
    parameter int KW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic [KW-1:0]    k,
    input  logic [CW-1:0]    carry_in,
    output logic [CW-1:0]    s
);

    // Enumerating every (i, j) pair keeps all bit selects constant after unrolling.
    always_comb begin
        s = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i + j == int'(k)) begin
                    s = s + CW'(ra[i] & rb[j]);
                end
            end
        end
    end

endmodule

// File: rtl/vedic_mult_seq.sv
// Sequential unsigned multiplier producing one product column per clock, with ready/valid on both sides.
module vedic_mult_seq
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CW = colw(WIDTH);
    localparam int KW = $clog2(2 * WIDTH);
    localparam logic [KW-1:0] LAST = KW'(cols(WIDTH) - 1);

    state_e           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [KW-1:0]    col;
    logic [CW-1:0]    carry;
    logic [CW-1:0]    s;

    vedic_column_sum #(
        .WIDTH (WIDTH),
        .CW    (CW),
        .KW    (KW)
    ) u_column (
        .ra       (ra),
        .rb       (rb),
        .k        (col),
        .carry_in (carry),
        .s        (s)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state == COLUMN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            p     <= '0;
            carry <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        p     <= '0;
                        carry <= '0;
                        col   <= '0;
                        state <= COLUMN;
                    end
                end
                COLUMN: begin
                    p[col] <= s[0];
                    carry  <= s >> 1;
                    col    <= col + 1'b1;
                    // The last column's carry is the top product bit.
                    if (col == LAST) begin
                        p[2*WIDTH-1] <= s[1];
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The running carry must stay below WIDTH, and the final carry must fit in one bit.
    always_ff @(posedge clk) begin
        if (!rst && state == COLUMN) begin
            assert ((s >> 1) < CW'(WIDTH))
            else $error("vedic_mult_seq: column carry out of range");
            if (col == LAST) begin
                assert ((s >> 1) <= CW'(1))
                else $error("vedic_mult_seq: final carry exceeds one bit");
            end
        end
    end
`endif

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq: WIDTH=8 and WIDTH=4 instances share clock and reset.
module tb_vedic_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, busy8;
    logic [15:0] p8;

    logic        iv4 = 1'b0, or4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ir4, ov4, busy4;
    logic [7:0]  p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vedic_mult_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .p         (p8),
        .busy      (busy8)
    );

    vedic_mult_seq #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .out_valid (ov4),
        .out_ready (or4),
        .p         (p4),
        .busy      (busy4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair on the 8-bit unit and wait (bounded) for out_valid.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int bcnt, output logic ir_after);
        a8 = x; b8 = y; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        a8 = ~x; b8 = ~y;
        ir_after = ir8;
        lat = 0; bcnt = 0;
        while (!ov8 && lat < 100) begin
            if (busy8) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic issue4(input logic [3:0] x, input logic [3:0] y, output int lat);
        a4 = x; b4 = y; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        a4 = ~x; b4 = ~y;
        lat = 0;
        while (!ov4 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic release8();
        or8 = 1'b1;
        step();
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p got %h want 0000", p8); end
        checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0 || p4 !== 8'h00) begin
            errors++; $display("FAIL reset_w4 got ir=%b ov=%b p=%h want 1 0 00", ir4, ov4, p4);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt; logic ira;
        issue8(8'd13, 8'd11, lat, bcnt, ira);
        checks++; if (ira !== 1'b0) begin errors++; $display("FAIL basic_in_ready_low got %b want 0", ira); end
        checks++; if (lat != 15) begin errors++; $display("FAIL basic_latency got %0d want 15", lat); end
        checks++; if (p8 !== 16'h008F) begin errors++; $display("FAIL basic_p got %h want 008f", p8); end
        release8();
    endtask

    task automatic test_all_ones();
        int lat, bcnt; logic ira;
        issue8(8'hFF, 8'hFF, lat, bcnt, ira);
        checks++; if (p8 !== 16'hFE01) begin errors++; $display("FAIL ones_p got %h want fe01", p8); end
        checks++; if (bcnt != 15) begin errors++; $display("FAIL ones_busy_cycles got %0d want 15", bcnt); end
        checks++; if (lat != 15) begin errors++; $display("FAIL ones_latency got %0d want 15", lat); end
        release8();
    endtask

    task automatic test_edge_operands();
        int lat, bcnt; logic ira;
        issue8(8'h00, 8'hA5, lat, bcnt, ira);
        checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL zero_p got %h want 0000", p8); end
        checks++; if (lat != 15) begin errors++; $display("FAIL zero_latency got %0d want 15", lat); end
        release8();
        issue8(8'h80, 8'h80, lat, bcnt, ira);
        checks++; if (p8 !== 16'h4000) begin errors++; $display("FAIL msb_p got %h want 4000", p8); end
        checks++; if (lat != 15) begin errors++; $display("FAIL msb_latency got %0d want 15", lat); end
        release8();
        issue8(8'hA5, 8'h3C, lat, bcnt, ira);
        checks++; if (p8 !== 16'h26AC) begin errors++; $display("FAIL mixed_p got %h want 26ac", p8); end
        release8();
    endtask

    task automatic test_backpressure();
        int lat, bcnt; logic ira;
        issue8(8'd13, 8'd11, lat, bcnt, ira);
        // A new pair offered while DONE must be ignored.
        a8 = 8'd5; b8 = 8'd7; iv8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (ov8 !== 1'b1 || ir8 !== 1'b0 || p8 !== 16'h008F) begin
                errors++; $display("FAIL hold_%0d got ov=%b ir=%b p=%h want 1 0 008f", i, ov8, ir8, p8);
            end
        end
        iv8 = 1'b0; or8 = 1'b1;
        step();
        or8 = 1'b0;
        checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++; $display("FAIL release got ov=%b ir=%b busy=%b want 0 1 0", ov8, ir8, busy8);
        end
        checks++; if (p8 !== 16'h008F) begin errors++; $display("FAIL release_p got %h want 008f", p8); end
        // out_ready high in IDLE does nothing.
        or8 = 1'b1;
        step();
        or8 = 1'b0;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            errors++; $display("FAIL idle_out_ready got ir=%b ov=%b want 1 0", ir8, ov8);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bcnt; logic ira;
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        or8 = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        or8 = 1'b0;
        checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++; $display("FAIL midrst_state got ov=%b ir=%b busy=%b want 0 1 0", ov8, ir8, busy8);
        end
        checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL midrst_p got %h want 0000", p8); end
        issue8(8'd3, 8'd5, lat, bcnt, ira);
        checks++; if (p8 !== 16'h000F || lat != 15) begin
            errors++; $display("FAIL after_rst got p=%h lat=%0d want 000f 15", p8, lat);
        end
        release8();
    endtask

    task automatic test_width4();
        int lat;
        logic [7:0] want;
        issue4(4'hF, 4'hF, lat);
        checks++; if (p4 !== 8'hE1) begin errors++; $display("FAIL w4_ones_p got %h want e1", p4); end
        checks++; if (lat != 7) begin errors++; $display("FAIL w4_latency got %0d want 7", lat); end
        or4 = 1'b1; step(); or4 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            logic [3:0] x, y;
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            want = {4'h0, x} * {4'h0, y};
            issue4(x, y, lat);
            checks++; if (p4 !== want || lat != 7) begin
                errors++; $display("FAIL w4_rand_%0d %0d*%0d got p=%h lat=%0d want %h 7", n, x, y, p4, lat, want);
            end
            or4 = 1'b1; step(); or4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_edge_operands();
        test_backpressure();
        test_reset_mid_op();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
